// File: rtl/ahb_master_req_ctrl_pkg.sv
// ahb_master_req_ctrl_pkg
//   Shared AHB types and helpers for the master request controller and
//   for slave models that reuse the burst address generator.
//   - hburst_type : AHB HBURST encoding
//   - htrans_type : AHB HTRANS encoding
//   - burst_len() : beats per burst (INCR is issued as a single beat)
//   - burst_is_wrap() : true for WRAP4/8/16
package ahb_master_req_ctrl_pkg;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_type;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_type;

  // INCR reports 1 so the master matches the arbiter's count_limit.
  function automatic logic [4:0] burst_len(input hburst_type b);
    case (b)
      WRAP4, INCR4:   burst_len = 5'd4;
      WRAP8, INCR8:   burst_len = 5'd8;
      WRAP16, INCR16: burst_len = 5'd16;
      default:        burst_len = 5'd1;
    endcase
  endfunction

  function automatic logic burst_is_wrap(input hburst_type b);
    burst_is_wrap = (b == WRAP4) || (b == WRAP8) || (b == WRAP16);
  endfunction

endpackage

// File: rtl/ahb_master_req_ctrl_addr_gen.sv
// ahb_burst_addr_gen
//   Combinational next-beat address for AHB bursts.
//   Incrementing: addr + (1<<size).
//   Wrapping    : the low log2(len*(1<<size)) bits wrap inside the burst
//                 window, upper bits are kept.
// Ports:
//   addr      in  current beat address
//   size      in  transfer size code
//   burst     in  burst kind
//   next_addr out address of the following beat
module ahb_burst_addr_gen
  import ahb_master_req_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  hburst_type        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] mask;

  always_comb begin
    step = ADDR_W'(1) << size;
    incr = addr + step;
    mask = (ADDR_W'(burst_len(burst)) << size) - ADDR_W'(1);
    if (burst_is_wrap(burst)) begin
      next_addr = (addr & ~mask) | (incr & mask);
    end else begin
      next_addr = incr;
    end
  end

endmodule

// File: rtl/ahb_master_req_ctrl.sv
// ahb_master_req_ctrl
//   Master-side bus request and burst engine. Accepts one burst command,
//   requests the bus, drives a pipelined NONSEQ/SEQ burst after grant and
//   releases the bus once the last data phase completes.
// Optional: define AHB_MASTER_GRANT_CHECK_EN to add the sticky grant_err
//   output flagging a grant loss in the middle of a burst.
// Ports:
//   hclk, hreset_n           clock, async active-low reset
//   cmd_valid/cmd_ready      client command handshake
//   cmd_addr/cmd_write/cmd_burst/cmd_size  burst command
//   wdata/wdata_ack          write beat from client, consumed on ack
//   rdata/rdata_valid        read beat to client
//   hreq/hgrant              arbiter request/grant (hgrant masked by ~hwait)
//   hwait                    slave stall
//   haddr/htrans/hwrite/hsize/hburst/hwdata/hrdata  AHB master signals
//   busy                     command in progress
module ahb_master_req_ctrl
  import ahb_master_req_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  hburst_type        cmd_burst,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              hreq,
  input  logic              hgrant,
  input  logic              hwait,
  output logic [ADDR_W-1:0] haddr,
  output htrans_type        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output hburst_type        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
`ifdef AHB_MASTER_GRANT_CHECK_EN
  output logic              grant_err,
`endif
  output logic              busy
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_LAST_DATA
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic              write_q;
  logic [2:0]        size_q;
  hburst_type        burst_q;
  logic [3:0]        beat_q;

  logic              cmd_fire;
  logic              addr_acc;
  logic              last_beat;
  logic              data_phase;

  ahb_burst_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .addr     (addr_q),
    .size     (size_q),
    .burst    (burst_q),
    .next_addr(addr_nx)
  );

  always_comb begin
    cmd_fire  = (state == S_IDLE) && cmd_valid;
    addr_acc  = (state == S_ADDR) && !hwait;
    last_beat = ({1'b0, beat_q} == (burst_len(burst_q) - 5'd1));
    // Data trails address by one beat: in ADDR at beat k the data phase of
    // beat k-1 is in flight; LAST_DATA carries the final beat's data.
    data_phase = ((state == S_ADDR) && (beat_q != '0)) || (state == S_LAST_DATA);

    state_nx = state;
    case (state)
      S_IDLE:      if (cmd_valid) state_nx = S_REQ;
      S_REQ:       if (hgrant) state_nx = S_ADDR;
      S_ADDR:      if (!hwait && last_beat) state_nx = S_LAST_DATA;
      S_LAST_DATA: if (!hwait) state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase

    cmd_ready   = (state == S_IDLE);
    busy        = (state != S_IDLE);
    hreq        = (state == S_REQ) || (state == S_ADDR);
    htrans      = TRANS_IDLE;
    if (state == S_ADDR) begin
      htrans = (beat_q == '0) ? TRANS_NONSEQ : TRANS_SEQ;
    end
    haddr       = addr_q;
    hwrite      = write_q;
    hsize       = size_q;
    hburst      = burst_q;
    wdata_ack   = data_phase && write_q && !hwait;
    rdata_valid = data_phase && !write_q && !hwait;
    rdata       = rdata_valid ? hrdata : '0;
    hwdata      = (data_phase && write_q) ? wdata : '0;
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      burst_q <= SINGLE;
      beat_q  <= '0;
    end else begin
      state <= state_nx;
      if (cmd_fire) begin
        addr_q  <= cmd_addr;
        write_q <= cmd_write;
        size_q  <= (cmd_size > MAX_SIZE) ? MAX_SIZE : cmd_size;
        burst_q <= cmd_burst;
        beat_q  <= '0;
      end else if (addr_acc && !last_beat) begin
        addr_q <= addr_nx;
        beat_q <= beat_q + 4'd1;
      end
    end
  end

`ifdef AHB_MASTER_GRANT_CHECK_EN
  // Grant vanishing without a stall after the first beat means the arbiter
  // re-arbitrated mid-burst; the burst itself is not altered.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      grant_err <= 1'b0;
    end else if ((state == S_ADDR) && (beat_q != '0) && !hgrant && !hwait) begin
      grant_err <= 1'b1;
    end
  end
`endif

endmodule
